// File: rtl/keypad_pkg.sv
// keypad_pkg: command codes, key indices and FSM state encoding shared with the security FSM.
package keypad_pkg;
    localparam logic [1:0] COM_NONE = 2'd0;
    localparam logic [1:0] COM_ARM  = 2'd1;
    localparam logic [1:0] COM_DIS  = 2'd2;
    localparam int KEY_ARM = 10;
    localparam int KEY_DIS = 11;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        EMIT         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: parameterised-width 2-flop synchroniser with synchronous active-low reset.
module keypad_sync #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: debounces 12 buttons into one-cycle command / digit events; KEYPAD_MULTI_REJECT_EN drops multi-key presses.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] keys,
    output logic [1:0]  command,
    output logic [3:0]  digit,
    output logic        input_digit
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    state_t        state;
    logic [11:0]   keys_s;
    logic [11:0]   snap;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic          multi;
    keypad_sync #(.WIDTH(12)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (keys),
        .q     (keys_s)
    );
    // Lowest-index set bit wins: digits before ARM before DISARM.
    always_comb begin
        idx = 4'd0;
        for (int i = 11; i >= 0; i--)
            if (snap[i]) idx = 4'(i);
    end
`ifdef KEYPAD_MULTI_REJECT_EN
    assign multi = $countones(snap) > 1;
`else
    assign multi = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            snap        <= '0;
            cnt         <= '0;
            command     <= COM_NONE;
            digit       <= '0;
            input_digit <= 1'b0;
        end else begin
            command     <= COM_NONE;
            digit       <= '0;
            input_digit <= 1'b0;
            case (state)
                IDLE:
                    if (keys_s != '0) begin
                        snap  <= keys_s;
                        cnt   <= '0;
                        state <= PRESS_WAIT;
                    end
                PRESS_WAIT:
                    if (keys_s != snap) state <= IDLE;
                    else if (cnt == LAST) begin
                        cnt <= '0;
                        if (multi) state <= RELEASE_WAIT;
                        else begin
                            state       <= EMIT;
                            input_digit <= idx < 4'd10;
                            digit       <= idx < 4'd10 ? idx : 4'd0;
                            command     <= idx == 4'(KEY_ARM) ? COM_ARM :
                                           idx == 4'(KEY_DIS) ? COM_DIS : COM_NONE;
                        end
                    end else cnt <= cnt + CW'(1);
                EMIT: begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end
                RELEASE_WAIT:
                    if (keys_s != '0) cnt <= '0;
                    else if (cnt == LAST) state <= IDLE;
                    else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Front-end for the home-security controller. Twelve raw push-buttons (digits 0–9, ARM, DISARM) are synchronised and debounced, then converted into the controller's keypad protocol: a one-cycle `command` code or a one-cycle `input_digit` strobe with `digit`. Exactly one protocol event is produced per debounced press, with none on release. The block sits between the board buttons and the security FSM.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles N required to accept a press or a release; legal range ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `keys`  in  12  raw asynchronous buttons, 1 = pressed; bit k (0–9) = digit k, bit 10 = ARM, bit 11 = DISARM.
- `command`  out  2  registered; 0 = NONE, 1 = ARM, 2 = DISARM; non-zero for exactly one cycle per accepted command key.
- `digit`  out  4  registered; value 0–9, valid only while `input_digit` = 1, otherwise 0.
- `input_digit`  out  1  registered one-cycle strobe per accepted digit key.

## Operation
- `keys` passes through a 2-flop synchroniser, producing `keys_s`.
- The FSM has four states: IDLE, PRESS_WAIT, EMIT, RELEASE_WAIT.
  - IDLE: if `keys_s` ≠ 0, latch `snap` = `keys_s`, clear the counter, go to PRESS_WAIT.
  - PRESS_WAIT: if `keys_s` ≠ `snap`, go to IDLE (bounce; no output). Else if count = N−1, go to EMIT. Else increment the count.
  - EMIT: lasts one cycle, then go to RELEASE_WAIT with the count cleared.
  - RELEASE_WAIT: if `keys_s` ≠ 0, clear the count. Else if count = N−1, go to IDLE. Else increment the count.
- Outputs are loaded on the edge that enters EMIT and cleared on the next edge.
  - Digit key: `input_digit` = 1, `digit` = k, `command` = 0.
  - ARM: `command` = 1. DISARM: `command` = 2. In both cases `input_digit` = 0 and `digit` = 0.
- Key selection from `snap`: the lowest-index set bit wins, so digits take priority over ARM, and ARM over DISARM. This applies when the configuration macro is undefined.
- A new press is never accepted until all keys have been seen released for N consecutive cycles. Held keys therefore do not auto-repeat.
- Counter width is $clog2(N)+1 and saturates at N−1. No wrap-around is possible.
- Reset (`reset` = 0):
  - state ← IDLE; synchroniser, `snap` and counter ← 0.
  - `command` = 0, `digit` = 0, `input_digit` = 0.
  - A reset mid-debounce or during EMIT aborts with no further pulse.
  - A key still held when reset releases is treated as a fresh press.

## Timing
- With `keys` stable from before edge 1, `keys_s` is non-zero after edge 2, IDLE exits on edge 3, and EMIT is entered on edge N+3. The output is high for the single cycle between edges N+3 and N+4. For N = 4 that is edges 7–8.
- Minimum spacing between two accepted presses is N+3 (press) + 1 (EMIT) + N (release) cycles, plus synchroniser delay.
- Any change of `keys_s` during PRESS_WAIT restarts from IDLE on the next edge. This includes adding a second key.
- Outputs never glitch: all three are flops and are mutually exclusive.

## Configuration
- `KEYPAD_MULTI_REJECT_EN`
  - Defined: if `snap` has more than one bit set when the count reaches N−1, go directly to RELEASE_WAIT and skip EMIT. No event is emitted.
  - Undefined: lowest-index priority as above; a multi-key press emits exactly one event.

## Structure
- `keypad_pkg` holds:
  - command constants COM_NONE = 0, COM_ARM = 1, COM_DIS = 2, shared with the security FSM;
  - key index constants KEY_ARM = 10, KEY_DIS = 11;
  - the state encoding IDLE = 0, PRESS_WAIT = 1, EMIT = 2, RELEASE_WAIT = 3.
- One sub-module, `keypad_sync`: a parameterised-width 2-flop synchroniser with the same synchronous active-low reset.
- Priority encoding and the FSM stay in `keypad_encoder`.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with `keys` = 0x001 → all outputs 0 throughout; after release, `input_digit` = 1 with `digit` = 0 at edge N+3.
- Clean press of digit 4 (`keys` = 0x010) for 20 cycles, N = 4 → exactly one `input_digit` pulse with `digit` = 4 at edge 7, then nothing until release.
- Bounce: `keys` = 0x400 toggling every 2 cycles for 10 cycles, then stable for 10 cycles → one `command` = 1 pulse only, 7 edges after the input becomes stable.
- Sequence ARM, 0, 1, 2, each held 10 cycles and separated by 10 idle cycles → `command` = 1, then `digit` = 0, 1, 2 strobes, in order, with no extra events.
- Multi-press `keys` = 0x806 held:
  - macro undefined → single `digit` = 1 strobe;
  - `KEYPAD_MULTI_REJECT_EN` defined → no output at all.
- Reset asserted during PRESS_WAIT (edge 5, N = 4) → no pulse at edge 7; the key still held after reset release is emitted N+3 edges later.
